// File: rtl/req_ack_mon_pkg.sv
// Shared types and helpers for the req/ack window monitor.
package req_ack_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    TIMEOUT = 2'd1,
    OVERLAP = 2'd2
  } err_code_e;

  localparam int unsigned MaxCntW = 32;

  // Saturating add clamped at 2**width-1; width must not exceed MaxCntW.
  function automatic logic [MaxCntW-1:0] sat_add(input logic [MaxCntW-1:0] cnt,
                                                 input logic [MaxCntW-1:0] inc,
                                                 input int unsigned        width);
    logic [MaxCntW:0] sum;
    logic [MaxCntW:0] lim;
    sum = {1'b0, cnt} + {1'b0, inc};
    lim = ({{MaxCntW{1'b0}}, 1'b1} << width) - {{MaxCntW{1'b0}}, 1'b1};
    return (sum > lim) ? lim[MaxCntW-1:0] : sum[MaxCntW-1:0];
  endfunction

endpackage

// File: rtl/req_ack_chan_fsm.sv
// One monitored channel: request edge detect, IDLE/WAIT FSM and ack window timer.
module req_ack_chan_fsm
  import req_ack_mon_pkg::*;
#(
  parameter int unsigned MAX_DLY = 5
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      enable_i,
  input  logic      sel_i,
  input  logic      req_i,
  input  logic      ack_i,
  output logic      pass_o,
  output logic      err_o,
  output logic      err_dbl_o,
  output err_code_e err_code_o,
  output logic      busy_o
);

  localparam int unsigned TW = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;

  chan_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic          req_q;
  logic          pass_q, err_q, err_dbl_q;
  err_code_e     err_code_q;

  logic rose, arm, last, timeout;

  assign rose    = req_i & ~req_q;
  assign arm     = enable_i & rose & sel_i;
  assign last    = (timer_q == TW'(MAX_DLY));
  assign timeout = ~ack_i & last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      req_q      <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      err_dbl_q  <= 1'b0;
      err_code_q <= NONE;
    end else begin
      // Edge history tracks req even while disabled.
      req_q      <= req_i;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      err_dbl_q  <= 1'b0;
      err_code_q <= NONE;
      if (!enable_i) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm) begin
              state_q <= WAIT;
              timer_q <= '0;
            end
          end
          WAIT: begin
            if (ack_i || last) begin
              pass_q  <= ack_i;
              state_q <= arm ? WAIT : IDLE;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
            // A re-pulsed req is an overlap; timeout wins the reported code.
            if (timeout || rose) begin
              err_q      <= 1'b1;
              err_code_q <= timeout ? TIMEOUT : OVERLAP;
              err_dbl_q  <= timeout & rose;
            end
          end
        endcase
      end
    end
  end

  assign pass_o     = pass_q;
  assign err_o      = err_q;
  assign err_dbl_o  = err_dbl_q;
  assign err_code_o = err_code_q;
  assign busy_o     = (state_q == WAIT);

endmodule

// File: rtl/req_ack_window_monitor.sv
// Multi-channel req/ack window checker: per-channel FSMs, error priority encode, counters.
module req_ack_window_monitor
  import req_ack_mon_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_DLY = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [SEL_W-1:0] bus_select,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   ack,
  output logic [NCH-1:0]   pass_vec,
  output logic [NCH-1:0]   err_vec,
  output logic             err_valid,
  output logic [SEL_W-1:0] err_ch,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  logic [NCH-1:0] err_dbl;
  logic [NCH-1:0] busy_vec;
  err_code_e      chan_code [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    req_ack_chan_fsm #(
      .MAX_DLY (MAX_DLY)
    ) u_chan (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .enable_i   (enable),
      .sel_i      (bus_select == SEL_W'(i)),
      .req_i      (req[i]),
      .ack_i      (ack[i]),
      .pass_o     (pass_vec[i]),
      .err_o      (err_vec[i]),
      .err_dbl_o  (err_dbl[i]),
      .err_code_o (chan_code[i]),
      .busy_o     (busy_vec[i])
    );
  end

  assign err_valid = |err_vec;
  assign busy      = |busy_vec;

  // Lowest-index erroring channel wins.
  always_comb begin
    err_ch   = '0;
    err_code = NONE;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (err_vec[i]) begin
        err_ch   = SEL_W'(i);
        err_code = chan_code[i];
      end
    end
  end

  logic [5:0] pass_inc, fail_inc;

  always_comb begin
    pass_inc = '0;
    fail_inc = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      pass_inc = pass_inc + 6'(pass_vec[i]);
      fail_inc = fail_inc + 6'(err_vec[i]) + 6'(err_dbl[i]);
    end
  end

  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= CNT_W'(sat_add(MaxCntW'(pass_cnt_q), MaxCntW'(pass_inc), CNT_W));
      fail_cnt_q <= CNT_W'(sat_add(MaxCntW'(fail_cnt_q), MaxCntW'(fail_inc), CNT_W));
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_req_ack_window_monitor.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_req_ack_window_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable;
  logic [1:0]  bus_select;
  logic [3:0]  req, ack;
  logic [3:0]  pass_vec, err_vec;
  logic        err_valid, busy;
  logic [1:0]  err_ch, err_code;
  logic [15:0] pass_cnt, fail_cnt;

  req_ack_window_monitor #(
    .NCH     (4),
    .MAX_DLY (5),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bus_select (bus_select),
    .req        (req),
    .ack        (ack),
    .pass_vec   (pass_vec),
    .err_vec    (err_vec),
    .err_valid  (err_valid),
    .err_ch     (err_ch),
    .err_code   (err_code),
    .busy       (busy),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt)
  );

  // Second instance: zero-width window and 2-bit saturating counters.
  logic       b_en;
  logic [0:0] b_sel, b_err_ch;
  logic [1:0] b_req, b_ack, b_pass_vec, b_err_vec, b_err_code, b_pass_cnt, b_fail_cnt;
  logic       b_err_valid, b_busy;

  req_ack_window_monitor #(
    .NCH     (2),
    .MAX_DLY (0),
    .CNT_W   (2)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (b_en),
    .bus_select (b_sel),
    .req        (b_req),
    .ack        (b_ack),
    .pass_vec   (b_pass_vec),
    .err_vec    (b_err_vec),
    .err_valid  (b_err_valid),
    .err_ch     (b_err_ch),
    .err_code   (b_err_code),
    .busy       (b_busy),
    .pass_cnt   (b_pass_cnt),
    .fail_cnt   (b_fail_cnt)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pv;
    logic [3:0] ev;
    logic [1:0] ch;
    logic [1:0] code;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [3:0] pv, input logic [3:0] ev,
                              input logic [1:0] ch, input logic [1:0] code);
    exp_t e;
    e.cyc = c; e.pv = pv; e.ev = ev; e.ch = ch; e.code = code;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && (pass_vec != 4'b0 || err_vec != 4'b0)) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc %0d pass %b err %b, expected no pulse",
                 cyc, pass_vec, err_vec);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.pv !== pass_vec || mon_e.ev !== err_vec ||
            mon_e.ch !== err_ch || mon_e.code !== err_code || err_valid !== (mon_e.ev != 0)) begin
          n_fail++;
          $display("FAIL pulse: got cyc %0d pass %b err %b ch %0d code %0d vld %b, expected cyc %0d pass %b err %b ch %0d code %0d",
                   cyc, pass_vec, err_vec, err_ch, err_code, err_valid,
                   mon_e.cyc, mon_e.pv, mon_e.ev, mon_e.ch, mon_e.code);
        end
      end
    end
  end

  // One request on ch; ack high only before edge T+ack_at; outcome at edge T+off.
  task automatic run_one(input int ch, input int ack_at, input bit exp_pass, input int off);
    int t;
    logic [3:0] bit_v;
    t = cyc + 1;
    bit_v = 4'b0001 << ch;
    if (exp_pass) sb.push_back(mk(t + off, bit_v, 4'b0, 2'd0, 2'd0));
    else          sb.push_back(mk(t + off, 4'b0, bit_v, 2'(ch), 2'd1));
    bus_select = 2'(ch);
    req[ch] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      ack[ch] = (k == ack_at);
      tick();
    end
    ack = '0;
    req = '0;
    tick();
    tick();
  endtask

  logic [3:0] tbl_req [14];
  logic [1:0] tbl_sel [14];

  initial begin
    reset_n = 1'b0; enable = 1'b0; bus_select = '0; req = '0; ack = '0;
    b_en = 1'b0; b_sel = '0; b_req = '0; b_ack = '0;
    tick();
    tick();
    check("rst_pass_vec", pass_vec, 0);
    check("rst_err_vec", err_vec, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();
    mon_en = 1'b1;

    run_one(2, 3, 1'b1, 3);   // pass mid-window
    run_one(0, -1, 1'b0, 6);  // no ack: timeout at T+6
    run_one(1, 6, 1'b1, 6);   // ack on last window edge
    run_one(3, 0, 1'b0, 6);   // ack only on the arming edge is ignored
    run_one(3, 7, 1'b0, 6);   // ack one edge late
    check("cnt_pass_a", pass_cnt, 2);
    check("cnt_fail_a", fail_cnt, 3);
    check("busy_idle_a", busy, 0);

    // ch3 rises unselected, later arms; ch1 times out+overlaps+re-arms, then overlaps.
    tbl_req = '{4'b1010, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010,
                4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
    tbl_sel = '{2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1,
                2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    begin
      int t;
      t = cyc + 1;
      sb.push_back(mk(t + 6, 4'b0000, 4'b0010, 2'd1, 2'd1));
      sb.push_back(mk(t + 8, 4'b0000, 4'b1010, 2'd1, 2'd2));
      sb.push_back(mk(t + 12, 4'b0000, 4'b0010, 2'd1, 2'd1));
    end
    for (int k = 0; k < 14; k++) begin
      req        = tbl_req[k];
      bus_select = tbl_sel[k];
      tick();
      if (k == 0) check("busy_armed", busy, 1);
    end
    req = '0;
    tick(); tick(); tick();
    check("cnt_fail_b", fail_cnt, 8);
    check("cnt_pass_b", pass_cnt, 2);
    check("busy_idle_b", busy, 0);

    // enable dropped mid-WAIT: silent abort, held-high req is not a new edge.
    bus_select = 2'd0;
    req[0] = 1'b1;
    tick(); tick();
    enable = 1'b0;
    tick();
    check("busy_disabled", busy, 0);
    tick();
    enable = 1'b1;
    repeat (8) tick();
    req = '0;
    tick();
    check("cnt_fail_en", fail_cnt, 8);
    check("busy_reenabled", busy, 0);

    // Reset mid-WAIT.
    bus_select = 2'd2;
    req[2] = 1'b1;
    tick(); tick();
    check("busy_pre_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    req = '0;
    check("busy_in_reset", busy, 0);
    check("pass_cnt_in_reset", pass_cnt, 0);
    check("fail_cnt_in_reset", fail_cnt, 0);
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("busy_post_reset", busy, 0);
    check("fail_cnt_post_reset", fail_cnt, 0);

    // MAX_DLY=0 instance: only T+1 counts; pass counter saturates at 3.
    b_en = 1'b1;
    b_sel = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) begin
      b_req[0] = 1'b1;
      tick();
      b_ack[0] = 1'b1;
      tick();
      check("b_pass_vec", b_pass_vec, 2'b01);
      b_ack = '0;
      b_req = '0;
      tick();
    end
    tick();
    check("b_pass_cnt_sat", b_pass_cnt, 3);
    b_req[0] = 1'b1;
    b_ack[0] = 1'b1;
    tick();
    b_ack = '0;
    tick();
    check("b_err_vec", b_err_vec, 2'b01);
    check("b_err_code", b_err_code, 1);
    b_req = '0;
    tick(); tick();
    check("b_fail_cnt", b_fail_cnt, 1);
    check("b_pass_cnt_hold", b_pass_cnt, 3);

    tick();
    mon_en = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
